// File: rtl/toggle_handshake_rx_pkg.sv
// rtl/toggle_handshake_rx_pkg.sv - shared types and limits for the toggle handshake receiver
package toggle_sync_pkg;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    IDLE   = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int DEFAULT_DATA_W  = 8;

endpackage

// File: rtl/toggle_handshake_rx_if.sv
// rtl/toggle_handshake_rx_if.sv - toggle request/ack plus valid/ready consumer bundle
interface toggle_handshake_rx_if
  import toggle_sync_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic              req_tgl_in;
  logic [DATA_W-1:0] data_in;
  logic              ack_tgl_out;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output req_tgl_in, data_in, out_ready,
    input  ack_tgl_out, out_valid, out_data
  );

  modport slave (
    input  req_tgl_in, data_in, out_ready,
    output ack_tgl_out, out_valid, out_data
  );

endinterface

// File: rtl/toggle_handshake_rx_sync_ff_chain.sv
// rtl/toggle_handshake_rx_sync_ff_chain.sv - N-flop single-bit synchronizer, async active-low reset to 0
module sync_ff_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/toggle_handshake_rx.sv
// rtl/toggle_handshake_rx.sv - toggle CDC receive end; optional stall timeout via TOGGLE_RX_TIMEOUT_EN
module toggle_handshake_rx
  import toggle_sync_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  toggle_handshake_rx_if.slave  bus,
  output logic                  overrun,
  input  logic                  overrun_clr,
  output logic                  timeout,
  output logic                  busy
);

  localparam int SETTLE_CNT_W = $clog2(SYNC_STAGES_MAX + 1);
  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SYNC_STAGES);

  state_t                  state;
  logic [SETTLE_CNT_W-1:0] settle_cnt;
  logic                    req_s;
  logic                    req_d;
  logic                    req_edge;
  logic                    accept;

  sync_ff_chain #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.req_tgl_in),
    .q     (req_s)
  );

  assign req_edge = req_s ^ req_d;
  assign accept   = bus.out_valid & bus.out_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_d           <= 1'b0;
      state           <= SETTLE;
      settle_cnt      <= '0;
      bus.ack_tgl_out <= 1'b0;
      bus.out_valid   <= 1'b0;
      bus.out_data    <= '0;
      overrun         <= 1'b0;
    end else begin
      req_d <= req_s;
      if (overrun_clr) begin
        overrun <= 1'b0;
      end
      case (state)
        SETTLE: begin
          // Align ack to the sender's idle phase so a req left high is not an event.
          if (settle_cnt == SETTLE_LAST) begin
            bus.ack_tgl_out <= req_s;
            state           <= IDLE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (req_edge) begin
            bus.out_data  <= bus.data_in;
            bus.out_valid <= 1'b1;
            state         <= HOLD;
          end
        end
        HOLD: begin
          if (req_edge) begin
            overrun <= 1'b1;
          end
          if (accept) begin
            bus.out_valid   <= 1'b0;
            bus.ack_tgl_out <= ~bus.ack_tgl_out;
            state           <= IDLE;
          end
        end
        default: state <= SETTLE;
      endcase
    end
  end

`ifdef TOGGLE_RX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_PRE  = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] hold_cnt;

  // Counter saturates so a cleared flag re-arms while the stall persists.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      if (overrun_clr) begin
        timeout <= 1'b0;
      end
      if (state == HOLD && !accept) begin
        if (hold_cnt != TMO_LAST) begin
          hold_cnt <= hold_cnt + 1'b1;
        end
        if (hold_cnt >= TMO_PRE) begin
          timeout <= 1'b1;
        end
      end else begin
        hold_cnt <= '0;
      end
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: doc/toggle_handshake_rx.md
Name: toggle_handshake_rx

Overview:
Receive end of the toggle-based clock-domain crossing. It runs entirely in the destination clock domain.
- Synchronizes a request toggle arriving from a foreign domain and detects each transition as one transaction.
- Captures the bundled data and presents it to a local consumer on a valid/ready interface.
- Returns an acknowledge toggle to the sender once the consumer accepts.
- Sits between the sender's toggle generator and destination-domain logic; it turns one-shot pulse crossings into flow-controlled transfers.

Parameters:
- DATA_W, 8, width of the bundled data bus.
- SYNC_STAGES, 2, flops in the req synchronizer (legal range 2..4).
- TIMEOUT_CYC, 256, consumer-stall limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  destination-domain clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_tgl_in  in  1  request toggle from the sender; asynchronous to clk.
- data_in  in  DATA_W  bundled data; the sender holds it stable from before its req toggle until it sees ack_tgl_out match.
- ack_tgl_out  out  1  acknowledge toggle back to the sender.
- out_valid  out  1  captured transaction available.
- out_ready  in  1  consumer accepts.
- out_data  out  DATA_W  captured data.
- overrun  out  1  sticky protocol-violation flag.
- overrun_clr  in  1  synchronous clear of overrun.
- timeout  out  1  sticky consumer-stall flag (optional feature).
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values (rst_n low, asynchronous): sync chain = 0, req_d = 0, state = SETTLE, settle counter = 0, ack_tgl_out = 0, out_valid = 0, out_data = 0, overrun = 0, timeout = 0.
- Synchronizer: req_tgl_in passes through SYNC_STAGES flops to give req_s. req_d is req_s delayed one cycle. edge = req_s ^ req_d (combinational).
- State SETTLE:
  - Lasts SYNC_STAGES+1 cycles after reset release; edges are ignored.
  - On exit, ack_tgl_out <= req_s so that ack matches req (idle phase), then go to IDLE.
  - A sender that left reset with req = 1 therefore generates no spurious event.
- State IDLE: on edge, out_data <= data_in, out_valid <= 1, go to HOLD.
- State HOLD:
  - out_valid and out_data hold steady until out_valid & out_ready is seen at a rising edge.
  - On that edge: out_valid <= 0, ack_tgl_out toggles, go to IDLE.
  - out_data retains the last value after the handshake.
- Latency:
  - A req toggle that first meets setup at rising edge k gives out_valid high after edge k+SYNC_STAGES.
  - Ack toggles on the same edge as the accepting handshake.
  - With out_ready held high, out_valid is high for exactly one cycle.
- Overrun:
  - An edge detected in HOLD, including the handshake cycle, is a sender protocol violation.
  - overrun <= 1 and the new event is dropped; out_data is not overwritten and ack does not toggle extra.
  - overrun_clr clears it; if set and clear coincide, set wins.
- Edges in SETTLE are neither events nor overruns.
- Reset mid-transaction: everything returns to reset values immediately and any pending transaction is lost. The sender is reset in the same reset domain by system convention.
- out_ready while out_valid = 0 has no effect.

Optional Feature:
- Macro TOGGLE_RX_TIMEOUT_EN.
- Defined:
  - An internal counter of width $clog2(TIMEOUT_CYC+1) counts cycles spent in HOLD.
  - timeout is set sticky when the count reaches TIMEOUT_CYC while still in HOLD.
  - The counter clears on leaving HOLD; overrun_clr also clears timeout.
  - The transaction itself continues to wait.
- Not defined: no counter logic is built; timeout is tied to 0.

Decomposition:
- Package toggle_sync_pkg: state enum (SETTLE, IDLE, HOLD), SYNC_STAGES_MIN = 2, SYNC_STAGES_MAX = 4, DEFAULT_DATA_W = 8.
- One sub-module, sync_ff_chain: a parameterized N-flop single-bit synchronizer with async active-low reset to 0. It is reusable by the sender for the ack return path.

Test Plan:
- Reset release with req_tgl_in = 1 held → after SYNC_STAGES+1 cycles ack_tgl_out = 1, out_valid never asserts, busy drops to 0.
- Single transfer: data_in = 8'hA5, toggle req 0→1, out_ready = 1 → out_valid high exactly one cycle, 2 cycles after the sampling edge; out_data = A5; ack_tgl_out toggles on that cycle.
- Back-pressure: three transfers 8'h11, 8'h22, 8'h33, each sent only after ack, with out_ready low for 10 cycles per transfer → out_valid and out_data held stable throughout; ack toggles only on acceptance; three acks total.
- Violation: second req toggle with data 8'hFF while in HOLD → overrun = 1, out_data stays at the first value, one ack only; overrun_clr pulse → overrun = 0.
- Reset mid-HOLD: assert rst_n low while out_valid = 1 → out_valid, ack_tgl_out, overrun all 0 immediately; FSM restarts in SETTLE.
- With TOGGLE_RX_TIMEOUT_EN and TIMEOUT_CYC = 16: out_ready held low → timeout rises after 16 HOLD cycles; accepting later completes normally with timeout still 1.
